// File: rtl/csr_spmv_pkg.sv
// ============================================================================
// csr_spmv_pkg
// Shared widths and sequencer state encoding for the CSR SpMV sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package csr_spmv_pkg;

    localparam int SPMV_DW = 32;
    localparam int SPMV_AW = 32;

    typedef logic [2:0] spmv_state_t;

    localparam spmv_state_t S_IDLE  = 3'd0;
    localparam spmv_state_t S_RPTR0 = 3'd1;
    localparam spmv_state_t S_RPTR  = 3'd2;
    localparam spmv_state_t S_COL   = 3'd3;
    localparam spmv_state_t S_VEC   = 3'd4;
    localparam spmv_state_t S_EMIT  = 3'd5;
    localparam spmv_state_t S_DONE  = 3'd6;

endpackage

`default_nettype wire

// File: rtl/csr_spmv_sequencer_if.sv
// ============================================================================
// csr_spmv_sequencer_if
// Command, dual read-port and result bundle of the CSR SpMV sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface csr_spmv_sequencer_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          start;
    logic [AW-1:0] row_base;
    logic [AW-1:0] wdata_col_base;
    logic [AW-1:0] matrix_base;
    logic [AW-1:0] v_values_base;
    logic [AW-1:0] num_rows;
    logic [AW-1:0] addr1;
    logic [DW-1:0] dataIn1;
    logic [AW-1:0] addr2;
    logic [DW-1:0] dataIn2;
    logic          y_valid;
    logic [AW-1:0] y_row;
    logic [DW-1:0] y_data;
    logic          busy;
    logic          done;

    // Sequencer side
    modport master (
        input  start, row_base, wdata_col_base, matrix_base, v_values_base, num_rows,
        input  dataIn1, dataIn2,
        output addr1, addr2,
        output y_valid, y_row, y_data, busy, done
    );

    // Memory image / command source / result consumer side
    modport slave (
        output start, row_base, wdata_col_base, matrix_base, v_values_base, num_rows,
        output dataIn1, dataIn2,
        input  addr1, addr2,
        input  y_valid, y_row, y_data, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/csr_spmv_mac.sv
// ============================================================================
// csr_spmv_mac
// Row accumulator: acc += mval * xval, wrapping, or saturating when
// CSR_SPMV_SAT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module csr_spmv_mac
    import csr_spmv_pkg::*;
#(
    parameter int DW = SPMV_DW
) (
    input  wire logic          Clk,
    input  wire logic          Rst,
    input  wire logic          clear,
    input  wire logic          en,
    input  wire logic [DW-1:0] mval,
    input  wire logic [DW-1:0] xval,
    output logic      [DW-1:0] acc_next
);

    logic [DW-1:0] r_acc;

`ifdef CSR_SPMV_SAT_EN
    logic [2*DW-1:0] w_prod_full;
    logic [DW-1:0]   w_prod;
    logic [DW:0]     w_sum;
    logic            r_sticky;

    assign w_prod_full = {{DW{1'b0}}, mval} * {{DW{1'b0}}, xval};
    assign w_prod      = (|w_prod_full[2*DW-1:DW]) ? {DW{1'b1}} : w_prod_full[DW-1:0];
    assign w_sum       = {1'b0, r_acc} + {1'b0, w_prod};
    // Once a row has clamped it stays clamped until the next clear
    assign acc_next    = (r_sticky | w_sum[DW]) ? {DW{1'b1}} : w_sum[DW-1:0];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_sticky <= 1'b0;
        end else if (clear) begin
            r_sticky <= 1'b0;
        end else if (en && w_sum[DW]) begin
            r_sticky <= 1'b1;
        end
    end
`else
    logic [DW-1:0] w_prod;

    assign w_prod   = mval * xval;
    assign acc_next = r_acc + w_prod;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_acc <= '0;
        end else if (clear) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= acc_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/csr_spmv_sequencer.sv
// ============================================================================
// csr_spmv_sequencer
// Sequences one CSR sparse-matrix x dense-vector product over two read ports,
// one result per row. Option: CSR_SPMV_SAT_EN (saturating accumulate).
// Revision: 1.0
// ============================================================================
`default_nettype none

module csr_spmv_sequencer
    import csr_spmv_pkg::*;
#(
    parameter int DW = SPMV_DW,
    parameter int AW = SPMV_AW
) (
    input  wire logic              Clk,
    input  wire logic              Rst,
    csr_spmv_sequencer_if.master   bus
);

    spmv_state_t   r_state;
    spmv_state_t   w_next_state;

    logic [AW-1:0] r_row_base;
    logic [AW-1:0] r_col_base;
    logic [AW-1:0] r_mat_base;
    logic [AW-1:0] r_vec_base;
    logic [AW-1:0] r_num_rows;
    logic [AW-1:0] r_row;
    logic [AW-1:0] r_k;
    logic [AW-1:0] r_kend;
    logic [AW-1:0] r_col;
    logic [DW-1:0] r_mval;

    logic          r_y_valid;
    logic [AW-1:0] r_y_row;
    logic [DW-1:0] r_y_data;

    logic [AW-1:0] w_k_inc;
    logic [AW-1:0] w_row_inc;
    logic [AW-1:0] w_rptr_data;
    logic [AW-1:0] w_addr1;
    logic [AW-1:0] w_addr2;
    logic [DW-1:0] w_acc_next;

    assign w_k_inc     = r_k + 1'b1;
    assign w_row_inc   = r_row + 1'b1;
    assign w_rptr_data = AW'(bus.dataIn1);

    csr_spmv_mac #(
        .DW (DW)
    ) u_mac (
        .Clk      (Clk),
        .Rst      (Rst),
        .clear    (r_state == S_RPTR),
        .en       (r_state == S_VEC),
        .mval     (r_mval),
        .xval     (bus.dataIn2),
        .acc_next (w_acc_next)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = (bus.num_rows == '0) ? S_DONE : S_RPTR0;
                end
            end
            S_RPTR0: w_next_state = S_RPTR;
            // kend <= k covers both empty and malformed rows
            S_RPTR:  w_next_state = (w_rptr_data <= r_k) ? S_EMIT : S_COL;
            S_COL:   w_next_state = S_VEC;
            S_VEC:   w_next_state = (w_k_inc == r_kend) ? S_EMIT : S_COL;
            S_EMIT:  w_next_state = (w_row_inc == r_num_rows) ? S_DONE : S_RPTR;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_addr1 = '0;
        w_addr2 = '0;
        case (r_state)
            S_RPTR0: w_addr1 = r_row_base;
            S_RPTR:  w_addr1 = r_row_base + w_row_inc;
            S_COL: begin
                w_addr1 = r_col_base + r_k;
                w_addr2 = r_mat_base + r_k;
            end
            S_VEC:   w_addr2 = r_vec_base + r_col;
            default: begin
                w_addr1 = '0;
                w_addr2 = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= S_IDLE;
            r_row_base <= '0;
            r_col_base <= '0;
            r_mat_base <= '0;
            r_vec_base <= '0;
            r_num_rows <= '0;
            r_row      <= '0;
            r_k        <= '0;
            r_kend     <= '0;
            r_col      <= '0;
            r_mval     <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_row_base <= bus.row_base;
                        r_col_base <= bus.wdata_col_base;
                        r_mat_base <= bus.matrix_base;
                        r_vec_base <= bus.v_values_base;
                        r_num_rows <= bus.num_rows;
                        r_row      <= '0;
                    end
                end
                S_RPTR0: r_k    <= w_rptr_data;
                S_RPTR:  r_kend <= w_rptr_data;
                S_COL: begin
                    r_col  <= AW'(bus.dataIn1);
                    r_mval <= bus.dataIn2;
                end
                S_VEC:   r_k   <= w_k_inc;
                S_EMIT:  r_row <= w_row_inc;
                default: r_row <= r_row;
            endcase
        end
    end

    // Result registers load on entry to EMIT so they are valid during EMIT
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_y_valid <= 1'b0;
            r_y_row   <= '0;
            r_y_data  <= '0;
        end else begin
            r_y_valid <= (w_next_state == S_EMIT);
            if (w_next_state == S_EMIT) begin
                r_y_row  <= r_row;
                r_y_data <= (r_state == S_VEC) ? w_acc_next : '0;
            end
        end
    end

    assign bus.addr1   = w_addr1;
    assign bus.addr2   = w_addr2;
    assign bus.y_valid = r_y_valid;
    assign bus.y_row   = r_y_row;
    assign bus.y_data  = r_y_data;
    assign bus.busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.done    = (r_state == S_DONE);

endmodule

`default_nettype wire
